// File: rtl/branch_pkg.sv
// Shared definitions for the branch-condition unit: condition codes,
// flag-vector bit positions, result-pulse states and the condition table function.
package branch_pkg;

    localparam int COND_NE = 0;
    localparam int COND_LE = 1;
    localparam int COND_EQ = 2;
    localparam int COND_GT = 3;
    localparam int COND_LT = 4;
    localparam int COND_GE = 5;
    localparam int COND_AL = 6;
    localparam int COND_NV = 7;

    // Flag vector is packed as {z, gt, lt}
    localparam int FLAG_LT = 0;
    localparam int FLAG_GT = 1;
    localparam int FLAG_Z  = 2;
    localparam int FLAG_W  = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RESULT = 1'b1
    } resState_t;

    function automatic logic condFn(input int code, input logic [FLAG_W-1:0] flags);
        case (code)
            COND_NE: return flags[FLAG_GT] | flags[FLAG_LT];
            COND_LE: return flags[FLAG_LT] | flags[FLAG_Z];
            COND_EQ: return flags[FLAG_Z];
            COND_GT: return flags[FLAG_GT];
            COND_LT: return flags[FLAG_LT];
            COND_GE: return flags[FLAG_GT] | flags[FLAG_Z];
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition evaluator: selects one entry of the condition table,
// applies inversion, and flags codes beyond the implemented range.
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int NUM_COND = 8,
    parameter int SEL_W    = 3
) (
    input  logic [FLAG_W-1:0] flags,
    input  logic [SEL_W-1:0]  condSel,
    input  logic              condInv,
    output logic              result,
    output logic              illegal
);

    localparam int TBL_SIZE = 2 ** SEL_W;

    logic [TBL_SIZE-1:0] condVec;

    generate
        for (genvar gi = 0; gi < TBL_SIZE; gi++) begin : g_cond
            if (gi < NUM_COND) begin : g_impl
                assign condVec[gi] = condFn(gi, flags);
            end else begin : g_unimpl
                assign condVec[gi] = 1'b0;
            end
        end
    endgenerate

    assign illegal = 32'(condSel) >= NUM_COND;

    // An illegal code yields a plain 0, regardless of inversion
    assign result = illegal ? 1'b0 : (condVec[condSel] ^ condInv);

endmodule

// File: rtl/branch_cond_unit.sv
// Registered branch-condition evaluator with a one-cycle taken pulse and sticky
// illegal-select error. Define BRANCH_STATS_EN to add saturating branch/taken counters.
module branch_cond_unit
    import branch_pkg::*;
#(
    parameter int NUM_COND = 8,
    parameter int SEL_W    = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             alu_zero,
    input  logic             alu_gt,
    input  logic             alu_lt,
    input  logic             flags_valid,
    input  logic             cond_req,
    input  logic [SEL_W-1:0] cond_sel,
    input  logic             cond_inv,
    output logic             res_valid,
    output logic             taken,
    output logic             stale,
`ifdef BRANCH_STATS_EN
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt,
`endif
    output logic             sel_err
);

    logic [FLAG_W-1:0] aluFlags;
    logic [FLAG_W-1:0] flagReg;
    logic [FLAG_W-1:0] effFlags;
    logic              freshReg;
    logic              bypass;
    logic              evalResult;
    logic              evalIllegal;
    logic              takenReg;
    logic              staleReg;
    logic              selErrReg;
    resState_t         stateReg;
    resState_t         stateNext;

    assign aluFlags = {alu_zero, alu_gt, alu_lt};
    assign bypass   = flags_valid & cond_req;
    assign effFlags = bypass ? aluFlags : flagReg;

    branch_cond_eval #(
        .NUM_COND (NUM_COND),
        .SEL_W    (SEL_W)
    ) u_eval (
        .flags   (effFlags),
        .condSel (cond_sel),
        .condInv (cond_inv),
        .result  (evalResult),
        .illegal (evalIllegal)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flagReg   <= '0;
            freshReg  <= 1'b0;
            takenReg  <= 1'b0;
            staleReg  <= 1'b0;
            selErrReg <= 1'b0;
        end else begin
            if (flags_valid) begin
                flagReg <= aluFlags;
            end
            // A bypassed load is consumed by its own evaluation, so it is not fresh
            if (cond_req) begin
                freshReg <= 1'b0;
            end else if (flags_valid) begin
                freshReg <= 1'b1;
            end
            takenReg <= cond_req & evalResult;
            staleReg <= cond_req & ~freshReg & ~bypass;
            if (cond_req && evalIllegal) begin
                selErrReg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stateReg <= ST_IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = ST_IDLE;
        if (cond_req) begin
            stateNext = ST_RESULT;
        end
    end

    always_comb begin
        res_valid = (stateReg == ST_RESULT);
        taken     = takenReg;
        stale     = staleReg;
        sel_err   = selErrReg;
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] branchCntReg;
    logic [CNT_W-1:0] takenCntReg;

    // Counters saturate at all-ones rather than wrapping
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            branchCntReg <= '0;
            takenCntReg  <= '0;
        end else begin
            if (cond_req && (branchCntReg != '1)) begin
                branchCntReg <= branchCntReg + 1'b1;
            end
            if (cond_req && evalResult && (takenCntReg != '1)) begin
                takenCntReg <= takenCntReg + 1'b1;
            end
        end
    end

    assign branch_cnt = branchCntReg;
    assign taken_cnt  = takenCntReg;
`else
    // Statistics disabled: no counter state exists in this build.
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed bench for branch_cond_unit: two instances (8 and 6 implemented codes)
// checked every cycle against a behavioural model, plus hand-computed literals.
module tb_branch_cond_unit;

    localparam int SEL_W = 3;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int NC_A = 8;
    localparam int NC_B = 6;

    logic clk = 1'b0;
    logic reset_n;
    logic alu_zero, alu_gt, alu_lt, flags_valid, cond_req, cond_inv;
    logic [SEL_W-1:0] cond_sel;

    logic rvA, tkA, stA, erA, rvB, tkB, stB, erB;
`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] bcA, tcA, bcB, tcB;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    branch_cond_unit #(.NUM_COND(NC_A), .SEL_W(SEL_W), .CNT_W(CNT_W)) dutA (
        .clk(clk), .reset_n(reset_n), .alu_zero(alu_zero), .alu_gt(alu_gt), .alu_lt(alu_lt),
        .flags_valid(flags_valid), .cond_req(cond_req), .cond_sel(cond_sel), .cond_inv(cond_inv),
        .res_valid(rvA), .taken(tkA), .stale(stA),
`ifdef BRANCH_STATS_EN
        .branch_cnt(bcA), .taken_cnt(tcA),
`endif
        .sel_err(erA));

    branch_cond_unit #(.NUM_COND(NC_B), .SEL_W(SEL_W), .CNT_W(CNT_W)) dutB (
        .clk(clk), .reset_n(reset_n), .alu_zero(alu_zero), .alu_gt(alu_gt), .alu_lt(alu_lt),
        .flags_valid(flags_valid), .cond_req(cond_req), .cond_sel(cond_sel), .cond_inv(cond_inv),
        .res_valid(rvB), .taken(tkB), .stale(stB),
`ifdef BRANCH_STATS_EN
        .branch_cnt(bcB), .taken_cnt(tcB),
`endif
        .sel_err(erB));

    // Behavioural model: relation-level meaning of each code
    function automatic bit modelCond(int numCond, int sel, bit inv, bit z, bit gt, bit lt);
        bit r;
        if (sel >= numCond) return 1'b0;
        case (sel)
            0: r = !z;
            1: r = lt || z;
            2: r = z;
            3: r = gt;
            4: r = lt;
            5: r = gt || z;
            6: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r != inv;
    endfunction

    bit [2:0] mFlags;
    bit       mFresh;
    bit       expValid, expStale;
    bit       expTaken [2];
    bit       expErr   [2];
    int       expBr    [2];
    int       expTk    [2];

    always @(posedge clk) begin
        bit byp;
        bit [2:0] use3;
        bit t;
        int nc;
        byp  = flags_valid && cond_req;
        use3 = byp ? {alu_zero, alu_gt, alu_lt} : mFlags;
        if (!reset_n) begin
            mFlags   <= '0;
            mFresh   <= 1'b0;
            expValid <= 1'b0;
            expStale <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                expTaken[k] <= 1'b0;
                expErr[k]   <= 1'b0;
                expBr[k]    <= 0;
                expTk[k]    <= 0;
            end
        end else begin
            if (flags_valid) mFlags <= {alu_zero, alu_gt, alu_lt};
            mFresh   <= cond_req ? 1'b0 : (flags_valid ? 1'b1 : mFresh);
            expValid <= cond_req;
            expStale <= cond_req && !mFresh && !byp;
            for (int k = 0; k < 2; k++) begin
                nc = (k == 0) ? NC_A : NC_B;
                t  = cond_req && modelCond(nc, int'(cond_sel), cond_inv, use3[2], use3[1], use3[0]);
                expTaken[k] <= t;
                if (cond_req && int'(cond_sel) >= nc) expErr[k] <= 1'b1;
                if (cond_req) expBr[k] <= (expBr[k] < CNT_MAX) ? expBr[k] + 1 : CNT_MAX;
                if (t)        expTk[k] <= (expTk[k] < CNT_MAX) ? expTk[k] + 1 : CNT_MAX;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compareAll();
        check("A.res_valid", int'(rvA), int'(expValid));
        check("A.taken",     int'(tkA), int'(expTaken[0]));
        check("A.stale",     int'(stA), int'(expStale));
        check("A.sel_err",   int'(erA), int'(expErr[0]));
        check("B.res_valid", int'(rvB), int'(expValid));
        check("B.taken",     int'(tkB), int'(expTaken[1]));
        check("B.stale",     int'(stB), int'(expStale));
        check("B.sel_err",   int'(erB), int'(expErr[1]));
`ifdef BRANCH_STATS_EN
        check("A.branch_cnt", int'(bcA), expBr[0]);
        check("A.taken_cnt",  int'(tcA), expTk[0]);
        check("B.branch_cnt", int'(bcB), expBr[1]);
        check("B.taken_cnt",  int'(tcB), expTk[1]);
`endif
    endtask

    // Drive one cycle of inputs at the falling edge, then compare after the next rise
    task automatic step(input bit fv, input bit [2:0] zgl, input bit req, input int sel, input bit inv);
        flags_valid = fv;
        {alu_zero, alu_gt, alu_lt} = zgl;
        cond_req = req;
        cond_sel = SEL_W'(sel);
        cond_inv = inv;
        @(posedge clk);
        @(negedge clk);
        compareAll();
        $display("[TB] cyc fv=%0b zgl=%03b req=%0b sel=%0d inv=%0b -> A rv=%0b tk=%0b st=%0b er=%0b | B tk=%0b er=%0b",
                 fv, zgl, req, sel, inv, rvA, tkA, stA, erA, tkB, erB);
    endtask

    initial begin
        bit expSweep [8];
        expSweep = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        reset_n = 1'b0;
        flags_valid = 0; alu_zero = 0; alu_gt = 0; alu_lt = 0;
        cond_req = 0; cond_sel = '0; cond_inv = 0;
        @(negedge clk);
        step(0, 3'b000, 1, 2, 0);   // request during reset is ignored
        step(0, 3'b000, 0, 0, 0);
        check("reset.res_valid", int'(rvA), 0);
        check("reset.sel_err", int'(erB), 0);
        reset_n = 1'b1;

        // Equal compare, then stale repeat
        step(1, 3'b100, 0, 0, 0);
        step(0, 3'b000, 1, 2, 0);
        check("eq.taken", int'(tkA), 1);
        check("eq.stale", int'(stA), 0);
        step(0, 3'b000, 1, 2, 0);
        check("eq2.taken", int'(tkA), 1);
        check("eq2.stale", int'(stA), 1);
        step(0, 3'b000, 0, 0, 0);
        check("idle.res_valid", int'(rvA), 0);
        step(1, 3'b100, 0, 0, 0);   // flags_valid alone: no pulse
        check("fvonly.res_valid", int'(rvA), 0);

        // Bypass with registered flags all zero
        step(1, 3'b000, 0, 0, 0);
        step(1, 3'b010, 1, 3, 0);
        check("byp.taken", int'(tkA), 1);
        check("byp.stale", int'(stA), 0);

        // Inversion sweep with gt captured
        step(1, 3'b010, 0, 0, 0);
        for (int inv = 0; inv < 2; inv++) begin
            for (int s = 0; s < 8; s++) begin
                step(0, 3'b000, 1, s, inv[0]);
                check($sformatf("sweepA.s%0d.i%0d", s, inv), int'(tkA), int'(expSweep[s] ^ inv[0]));
            end
        end
        check("illegal.B.taken", int'(tkB), 0);
        check("illegal.B.res_valid", int'(rvB), 1);
        check("illegal.B.sel_err", int'(erB), 1);
        check("legal.A.sel_err", int'(erA), 0);
        step(0, 3'b000, 1, 0, 0);
        check("sticky.B.sel_err", int'(erB), 1);

        // Back-to-back: five pulses
        for (int i = 0; i < 5; i++) begin
            step(0, 3'b000, 1, 6, 0);
            check($sformatf("b2b.rv%0d", i), int'(rvA), 1);
        end
        // Back-to-back with reset on the third request
        for (int i = 0; i < 5; i++) begin
            reset_n = (i == 2) ? 1'b0 : 1'b1;
            step(0, 3'b000, 1, 6, 0);
            if (i == 2) begin
                check("rst.res_valid", int'(rvA), 0);
                check("rst.taken", int'(tkA), 0);
                check("rst.sel_err", int'(erB), 0);
            end else begin
                check($sformatf("rstb2b.rv%0d", i), int'(rvA), 1);
            end
        end
        reset_n = 1'b1;

        // Saturation: 20 always-taken requests (illegal on B)
        for (int i = 0; i < 20; i++) step(0, 3'b000, 1, 6, 0);
        step(0, 3'b000, 0, 0, 0);
        step(0, 3'b000, 0, 0, 0);
`ifdef BRANCH_STATS_EN
        check("sat.A.branch_cnt", int'(bcA), 15);
        check("sat.A.taken_cnt",  int'(tcA), 15);
        check("sat.B.branch_cnt", int'(bcB), 15);
        check("sat.B.taken_cnt",  int'(tcB), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_cond_unit.md
# branch_cond_unit

Registered branch-condition evaluator for the multi-cycle datapath, between the ALU flag outputs and the PC-write-condition AND gate. It captures ALU flags when the control FSM strobes them and evaluates a selectable condition from a parametrised table, with optional inversion. It delivers a one-cycle `taken` pulse with a sticky illegal-select error. Optional saturating branch statistics counters.

## Interface
- `NUM_COND`, default 8: number of implemented condition codes, from 4 to 8.
- `SEL_W`, default 3: width of `cond_sel`; must satisfy 2^SEL_W >= NUM_COND.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `alu_zero` in 1: ALU zero flag.
- `alu_gt` in 1: ALU greater-than flag.
- `alu_lt` in 1: ALU less-than flag.
- `flags_valid` in 1: capture the three ALU flags this cycle.
- `cond_req` in 1: evaluate a condition this cycle.
- `cond_sel` in SEL_W: condition code.
- `cond_inv` in 1: invert the condition result.
- `res_valid` out 1: result pulse.
- `taken` out 1: branch-taken result, qualified by `res_valid`.
- `stale` out 1: the evaluation used flags already consumed by a previous evaluation.
- `sel_err` out 1: sticky illegal-code error.
- `branch_cnt` out CNT_W: evaluations counted. Present only with `BRANCH_STATS_EN`.
- `taken_cnt` out CNT_W: taken results counted. Present only with `BRANCH_STATS_EN`.

## Operation
- Flag register `{z,gt,lt}`:
  - Loads on `flags_valid`.
  - A `fresh` bit sets on load and clears on evaluation.
- Effective flags for an evaluation:
  - The incoming ALU flags when `flags_valid` and `cond_req` coincide (bypass).
  - Otherwise the registered flags.
- Condition table, indexed by `cond_sel`:
  - 0: gt|lt (not equal)
  - 1: lt|z (less or equal)
  - 2: z (equal)
  - 3: gt
  - 4: lt
  - 5: gt|z (greater or equal)
  - 6: 1 (always)
  - 7: 0 (never)
- Codes 0–3 are always implemented. Codes at index NUM_COND or above are illegal.
- Illegal code:
  - Raw result forced to 0.
  - `cond_inv` is ignored.
  - `sel_err` is set and stays set until reset.
- Result: `taken = raw ^ cond_inv`.
- `stale` is asserted with `res_valid` when `fresh` was 0 at request and there was no bypass.
- Requests are fully pipelined: one per cycle accepted, no backpressure.
- Two states per request:
  - IDLE: no pulse.
  - RESULT: one-cycle `res_valid`, then back to IDLE or RESULT depending on the next request.

## Timing
- Latency: `cond_req` in cycle N gives `res_valid`, `taken` and `stale` in cycle N+1, all registered.
- `res_valid` is exactly one cycle per request. `taken` and `stale` are 0 whenever `res_valid` is 0.
- `flags_valid` alone gives no output.
- `sel_err` is visible in cycle N+1 of the offending request.
- `reset_n` low at a rising edge zeroes all of the following, and any request in flight is dropped with no pulse:
  - flag register and `fresh`
  - `res_valid`, `taken`, `stale`, `sel_err`
  - both counters
- A `cond_req` in the same cycle as reset is ignored.

## Configuration
- With `BRANCH_STATS_EN` defined:
  - `branch_cnt` increments on each result pulse, including illegal codes.
  - `taken_cnt` increments when `taken` is 1.
  - Both are updated in the same cycle as `res_valid` is registered.
  - Both saturate at all-ones and never wrap.
- Without it: the counter ports and logic are absent. All other behaviour is identical.

## Structure
- Package `branch_pkg` holds:
  - condition-code localparams: `COND_NE`, `COND_LE`, `COND_EQ`, `COND_GT`, `COND_LT`, `COND_GE`, `COND_AL`, `COND_NV`
  - flag-vector index constants
- Sub-module `branch_cond_eval`: purely combinational. Maps flags, `cond_sel` and `cond_inv` to raw result and illegal flag; parametrised by `NUM_COND`.
- Top level holds:
  - flag and `fresh` registers
  - output registers
  - sticky error
  - counters, under the macro

## Test plan
- Equal compare: flags z=1 captured, then `cond_req` sel=2 inv=0 → cycle+1 `res_valid`=1, `taken`=1, `stale`=0. Repeat the same request → `taken`=1, `stale`=1.
- Bypass: flags_valid with gt=1 and `cond_req` sel=3 in the same cycle, registered flags all 0 → `taken`=1, `stale`=0.
- Inversion sweep: gt=1 captured; sel 0–7 with inv=0 then inv=1 → expected taken `1,0,0,1,0,1,1,0`, then the complement.
- Illegal code: NUM_COND=6, sel=7 inv=1 → `taken`=0, `res_valid`=1, `sel_err`=1, and `sel_err` stays 1 until reset.
- Back-to-back: requests in 5 consecutive cycles → 5 consecutive `res_valid` pulses. Assert reset at the 3rd → no pulse in the following cycle and all outputs 0.
- `BRANCH_STATS_EN` with CNT_W=4: 20 taken requests → `branch_cnt`=15 and `taken_cnt`=15, held saturated.
